store_buffer: RTL and testbench

STORE_BUFFER -- requirements
Module: store_buffer

---
 rtl/store_buffer_pkg.sv | 13 +
 rtl/sb_match.sv | 32 +++
 rtl/store_buffer.sv | 141 ++++++++++++++
 tb/tb_store_buffer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/store_buffer_pkg.sv
// Shared defaults and entry record for the core-side store buffer.
package store_buffer_pkg;

    localparam int unsigned SB_DEPTH = 4;
    localparam int unsigned SB_AW    = 32;
    localparam int unsigned SB_DW    = 32;

    typedef struct packed {
        logic [SB_AW-1:0] addr;
        logic [SB_DW-1:0] data;
    } sb_entry_t;

endpackage

// File: rtl/sb_match.sv
// Youngest-match search of a load address over the pending store entries.
module sb_match #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 32
) (
    input  logic [DEPTH-1:0]         valid,
    input  logic [AW-1:0]            addr [DEPTH],
    input  logic [$clog2(DEPTH)-1:0] head,
    input  logic [AW-1:0]            key,
    output logic                     hit,
    output logic [$clog2(DEPTH)-1:0] hit_idx
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [PW-1:0] idx;

    // Walk oldest to youngest from head; the last match seen is the youngest.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        idx     = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            idx = head + PW'(k);
            if (valid[idx] && (addr[idx] == key)) begin
                hit     = 1'b1;
                hit_idx = idx;
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Store buffer between core and data memory: queues stores, forwards to loads,
// and drains to memory in program order whenever the memory port is idle.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = SB_DEPTH,
    parameter int unsigned AW    = SB_AW,
    parameter int unsigned DW    = SB_DW
) (
    input  logic          clk,
    input  logic          reset_s,
    input  logic [AW-1:0] data_addr,
    input  logic [DW-1:0] data_out,
    input  logic          data_read,
    input  logic          data_write,
    output logic [DW-1:0] data_in,
    output logic          stall,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_read,
    output logic          mem_write,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready,
    output logic          buf_empty
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    sb_entry_t      ent_q [DEPTH];
    sb_entry_t      ent_d [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [PW-1:0]  head_q, head_d;
    logic [PW-1:0]  tail_q, tail_d;
    logic [CW-1:0]  count_q, count_d;

    logic [AW-1:0]  ent_addr [DEPTH];
    logic           hit;
    logic [PW-1:0]  hit_idx;

    logic           load_only;
    logic           load_miss;
    logic           load_issue;
    logic           drain;
    logic           enq;

    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            ent_addr[i] = AW'(ent_q[i].addr);
        end
    end

    sb_match #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_match (
        .valid   (valid_q),
        .addr    (ent_addr),
        .head    (head_q),
        .key     (data_addr),
        .hit     (hit),
        .hit_idx (hit_idx)
    );

    // A load miss owns the memory port; draining only uses it when it is free.
    always_comb begin
        load_only  = data_read && !data_write;
        load_miss  = load_only && !hit;
        load_issue = load_miss && mem_ready;
        drain      = (count_q != '0) && mem_ready && !load_issue;
        enq        = data_write && ((count_q < CW'(DEPTH)) || drain);
    end

    // Core and memory side outputs; everything is forced quiet during reset.
    always_comb begin
        data_in   = '0;
        stall     = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        buf_empty = (count_q == '0);
        if (reset_s) begin
            if (load_only && hit) begin
                data_in = DW'(ent_q[hit_idx].data);
            end else if (load_issue) begin
                data_in = mem_rdata;
            end
            stall     = (load_miss && !mem_ready) || (data_write && !enq);
            mem_read  = load_issue;
            mem_write = drain;
            if (load_issue) begin
                mem_addr = data_addr;
            end else if (drain) begin
                mem_addr  = AW'(ent_q[head_q].addr);
                mem_wdata = DW'(ent_q[head_q].data);
            end
        end else begin
            buf_empty = 1'b1;
        end
    end

    // Next-state: drain retires head before enqueue may reuse the same slot.
    always_comb begin
        ent_d   = ent_q;
        valid_d = valid_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (drain) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PW'(1);
        end
        if (enq) begin
            ent_d[tail_q].addr = SB_AW'(data_addr);
            ent_d[tail_q].data = SB_DW'(data_out);
            valid_d[tail_q]    = 1'b1;
            tail_d             = tail_q + PW'(1);
        end
        count_d = count_q + CW'(enq) - CW'(drain);
    end

    always_ff @(posedge clk or negedge reset_s) begin
        if (!reset_s) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            ent_q   <= ent_d;
            valid_q <= valid_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer with a queue-based reference model.
module tb_store_buffer;

    localparam int unsigned DEPTH = 4;

    logic        clk        = 1'b0;
    logic        reset_s    = 1'b0;
    logic [31:0] data_addr  = '0;
    logic [31:0] data_out   = '0;
    logic        data_read  = 1'b0;
    logic        data_write = 1'b0;
    logic [31:0] data_in;
    logic        stall;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_rdata  = '0;
    logic        mem_ready  = 1'b0;
    logic        buf_empty;

    store_buffer #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
        .clk        (clk),
        .reset_s    (reset_s),
        .data_addr  (data_addr),
        .data_out   (data_out),
        .data_read  (data_read),
        .data_write (data_write),
        .data_in    (data_in),
        .stall      (stall),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .buf_empty  (buf_empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } ent_t;

    ent_t mq[$];
    ent_t wlog[$];
    int   vectors     = 0;
    int   miscompares = 0;
    bit   pend_dr     = 0;
    bit   pend_en     = 0;
    ent_t pend_ent;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: the pending stores are a plain FIFO queue; outputs follow the rules directly.
    always @(negedge clk) begin : cmp
        bit          hit, lo, miss, li, dr, en, e_stall;
        logic [31:0] hd, e_din;
        hit = 0; hd = '0;
        if (!reset_s) begin
            pend_dr = 0;
            pend_en = 0;
            chk("rst_data_in", data_in, 32'h0);
            chk("rst_stall", 32'(stall), 32'h0);
            chk("rst_mem_read", 32'(mem_read), 32'h0);
            chk("rst_mem_write", 32'(mem_write), 32'h0);
            chk("rst_buf_empty", 32'(buf_empty), 32'h1);
        end else begin
            for (int i = mq.size() - 1; i >= 0; i--) begin
                if (mq[i].a == data_addr) begin
                    hit = 1;
                    hd  = mq[i].d;
                    break;
                end
            end
            lo      = data_read && !data_write;
            miss    = lo && !hit;
            li      = miss && mem_ready;
            dr      = (mq.size() > 0) && mem_ready && !li;
            en      = data_write && ((mq.size() < DEPTH) || dr);
            e_stall = (miss && !mem_ready) || (data_write && !en);
            e_din   = (lo && hit) ? hd : (li ? mem_rdata : 32'h0);
            chk("data_in", data_in, e_din);
            chk("stall", 32'(stall), 32'(e_stall));
            chk("mem_read", 32'(mem_read), 32'(li));
            chk("mem_write", 32'(mem_write), 32'(dr));
            chk("buf_empty", 32'(buf_empty), 32'(mq.size() == 0));
            if (li) chk("mem_addr_rd", mem_addr, data_addr);
            if (dr) begin
                chk("mem_addr_wr", mem_addr, mq[0].a);
                chk("mem_wdata", mem_wdata, mq[0].d);
            end
            pend_dr    = dr;
            pend_en    = en;
            pend_ent.a = data_addr;
            pend_ent.d = data_out;
        end
        if (mem_write === 1'b1) wlog.push_back('{mem_addr, mem_wdata});
    end

    always @(posedge clk or negedge reset_s) begin
        if (!reset_s) begin
            mq.delete();
        end else begin
            if (pend_dr) void'(mq.pop_front());
            if (pend_en) mq.push_back(pend_ent);
        end
    end

    // One core cycle: inputs change after the rising edge, return after outputs settle.
    task automatic step(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input logic rdy, input logic [31:0] rdat);
        @(posedge clk);
        #1;
        data_read  = rd;
        data_write = wr;
        data_addr  = a;
        data_out   = d;
        mem_ready  = rdy;
        mem_rdata  = rdat;
        @(negedge clk);
        #1;
    endtask

    int wbase;

    initial begin
        // Reset held: a stalling-shaped request must still produce quiet outputs.
        step(1, 0, 32'h10, 0, 0, 32'hDEAD_BEEF);
        chk("lit_rst_stall", 32'(stall), 32'h0);
        chk("lit_rst_empty", 32'(buf_empty), 32'h1);
        reset_s = 1'b1;

        // Forwarding from a single pending store.
        step(0, 1, 32'h10, 32'hAAAA_0001, 0, 0);
        step(1, 0, 32'h10, 0, 0, 32'h1111_1111);
        chk("lit_fwd_data", data_in, 32'hAAAA_0001);
        chk("lit_fwd_stall", 32'(stall), 32'h0);
        chk("lit_fwd_mem_read", 32'(mem_read), 32'h0);
        step(0, 0, 0, 0, 1, 0);
        chk("lit_drain_addr", mem_addr, 32'h10);
        step(0, 0, 0, 0, 1, 0);
        chk("lit_empty_after", 32'(buf_empty), 32'h1);

        // Full buffer stalls a fifth store until memory frees a slot.
        for (int i = 0; i < 4; i++) step(0, 1, 32'h100 + 32'(i), 32'hB0 + 32'(i), 0, 0);
        step(0, 1, 32'h104, 32'hB4, 0, 0);
        chk("lit_full_stall", 32'(stall), 32'h1);
        step(0, 1, 32'h104, 32'hB4, 0, 0);
        chk("lit_full_stall2", 32'(stall), 32'h1);
        step(0, 1, 32'h104, 32'hB4, 1, 0);
        chk("lit_full_accept", 32'(stall), 32'h0);
        chk("lit_full_drain", mem_addr, 32'h100);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1, 0);
        chk("lit_full_empty", 32'(buf_empty), 32'h1);

        // Same-address stores stay separate and drain in order.
        wbase = wlog.size();
        step(0, 1, 32'h20, 32'h1, 0, 0);
        step(0, 1, 32'h20, 32'h2, 0, 0);
        step(1, 0, 32'h20, 0, 0, 32'h5555_5555);
        chk("lit_young_data", data_in, 32'h2);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0);
        chk("lit_wlog_n", 32'(wlog.size() - wbase), 32'h2);
        chk("lit_wlog0_d", wlog[wbase].d, 32'h1);
        chk("lit_wlog1_d", wlog[wbase+1].d, 32'h2);
        chk("lit_wlog1_a", wlog[wbase+1].a, 32'h20);

        // Load miss preempts drain; drain resumes afterwards.
        step(0, 1, 32'h40, 32'h7, 0, 0);
        step(0, 1, 32'h44, 32'h8, 0, 0);
        step(1, 0, 32'h30, 0, 1, 32'h1234);
        chk("lit_miss_read", 32'(mem_read), 32'h1);
        chk("lit_miss_nowrite", 32'(mem_write), 32'h0);
        chk("lit_miss_data", data_in, 32'h1234);
        step(0, 0, 0, 0, 1, 0);
        chk("lit_resume_addr", mem_addr, 32'h40);
        step(1, 0, 32'h30, 0, 0, 32'h9999);
        chk("lit_miss_stall", 32'(stall), 32'h1);
        chk("lit_miss_stall_data", data_in, 32'h0);
        step(1, 1, 32'h50, 32'h9, 0, 32'h7777);
        chk("lit_rdwr_data", data_in, 32'h0);
        chk("lit_rdwr_stall", 32'(stall), 32'h0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 0);

        // Reset mid-cycle discards pending stores.
        for (int i = 0; i < 3; i++) step(0, 1, 32'h60 + 32'(4 * i), 32'hC0 + 32'(i), 0, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("lit_pend_notempty", 32'(buf_empty), 32'h0);
        wbase = wlog.size();
        #2;
        reset_s = 1'b0;
        #1;
        chk("lit_midrst_empty", 32'(buf_empty), 32'h1);
        chk("lit_midrst_nowrite", 32'(mem_write), 32'h0);
        step(0, 0, 0, 0, 1, 0);
        reset_s = 1'b1;
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 0);
        chk("lit_midrst_wlog", 32'(wlog.size() - wbase), 32'h0);

        // Eight back-to-back stores wrap the pointers twice.
        wbase = wlog.size();
        for (int i = 0; i < 8; i++) step(0, 1, 32'h200 + 32'(4 * i), 32'hD0 + 32'(i), 1, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 0);
        chk("lit_wrap_n", 32'(wlog.size() - wbase), 32'h8);
        chk("lit_wrap_empty", 32'(buf_empty), 32'h1);
        for (int i = 0; i < 8; i++) begin
            if (wbase + i < wlog.size()) begin
                chk("lit_wrap_a", wlog[wbase+i].a, 32'h200 + 32'(4 * i));
                chk("lit_wrap_d", wlog[wbase+i].d, 32'hD0 + 32'(i));
            end else begin
                chk("lit_wrap_missing", 32'(wlog.size() - wbase), 32'(i + 1));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
